// File: rtl/mem_line_responder.sv
// Main-memory line responder on the cache<->memory bus: serves READ_LINE / WRITE_LINE
// with a fixed response latency, moving one cache line per transaction over D2.
module mem_line_responder #(
    parameter int MEM_SIZE          = 2**18,
    parameter int CACHE_LINE_SIZE   = 16,
    parameter int CACHE_OFFSET_SIZE = 4,
    parameter int ADDR2_BUS_SIZE    = 14,
    parameter int DATA2_BUS_SIZE    = 16,
    parameter int CTR2_BUS_SIZE     = 2,
    parameter int RESP_DELAY        = 50
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR2_BUS_SIZE-1:0] A2,
    inout  wire  [DATA2_BUS_SIZE-1:0] D2,
    inout  wire  [CTR2_BUS_SIZE-1:0]  C2
);

    localparam int LINE_BITS = CACHE_LINE_SIZE * 8;
    localparam int BEATS     = LINE_BITS / DATA2_BUS_SIZE;
    localparam int BEAT_W    = $clog2(BEATS);
    localparam int NUM_LINES = MEM_SIZE / CACHE_LINE_SIZE;
    localparam int ADDR_W    = ADDR2_BUS_SIZE + CACHE_OFFSET_SIZE;
    localparam int CNT_W     = $clog2(RESP_DELAY + 1);

    localparam logic [CNT_W-1:0]         DELAY_CNT = CNT_W'(RESP_DELAY);
    localparam logic [BEAT_W-1:0]        LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [CTR2_BUS_SIZE-1:0] CMD_RESP  = CTR2_BUS_SIZE'(1);
    localparam logic [CTR2_BUS_SIZE-1:0] CMD_READ  = CTR2_BUS_SIZE'(2);
    localparam logic [CTR2_BUS_SIZE-1:0] CMD_WRITE = CTR2_BUS_SIZE'(3);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_SEND,
        WR_RECV,
        WR_WAIT,
        WR_ACK
    } state_t;

    state_t                      state_reg, state_next;
    logic [CNT_W-1:0]            cnt_reg, cnt_next;
    logic [BEAT_W-1:0]           beat_reg, beat_next;
    logic [BEAT_W-1:0]           beat_inc;
    logic [ADDR2_BUS_SIZE-1:0]   addr_reg, addr_next;
    logic                        c2_oe_reg, c2_oe_next;
    logic                        d2_oe_reg, d2_oe_next;
    logic [DATA2_BUS_SIZE-1:0]   d2_out_reg, d2_out_next;

    logic                        cap_en;
    logic [BEAT_W-1:0]           cap_beat;
    logic                        commit_en;
    logic [LINE_BITS-1:0]        wr_line_reg;

    // Storage: line-wide RAM plus a per-line "written since reset" flag. Lines never
    // written since reset read back the power-on pattern, which makes reset instant.
    logic [LINE_BITS-1:0]        line_ram [NUM_LINES];
    logic [NUM_LINES-1:0]        dirty_reg;
    logic                        dirty_hit_reg;
    logic [LINE_BITS-1:0]        rd_line_reg;
    logic [LINE_BITS-1:0]        pattern_line;
    logic [LINE_BITS-1:0]        merged_line;
    logic [DATA2_BUS_SIZE-1:0]   merged_beat [BEATS];

    generate
        for (genvar gi = 0; gi < CACHE_LINE_SIZE; gi++) begin : g_pattern
            logic [ADDR_W-1:0] byte_addr;
            assign byte_addr = {addr_reg, CACHE_OFFSET_SIZE'(gi)};
            assign pattern_line[8*gi +: 8] = byte_addr[7:0] ^ byte_addr[15:8]
                                           ^ {6'b0, byte_addr[17:16]};
        end
    endgenerate

    assign merged_line = dirty_hit_reg ? rd_line_reg : pattern_line;

    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
            assign merged_beat[gi] = merged_line[DATA2_BUS_SIZE*gi +: DATA2_BUS_SIZE];
        end
    endgenerate

    assign beat_inc = beat_reg + 1'b1;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        beat_next   = beat_reg;
        addr_next   = addr_reg;
        c2_oe_next  = 1'b0;
        d2_oe_next  = 1'b0;
        d2_out_next = d2_out_reg;
        cap_en      = 1'b0;
        cap_beat    = beat_reg;
        commit_en   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (C2 == CMD_READ) begin
                    addr_next  = A2;
                    cnt_next   = CNT_W'(1);
                    state_next = RD_WAIT;
                end else if (C2 == CMD_WRITE) begin
                    addr_next  = A2;
                    cnt_next   = CNT_W'(1);
                    beat_next  = BEAT_W'(1);
                    cap_en     = 1'b1;
                    cap_beat   = '0;
                    state_next = WR_RECV;
                end
            end
            RD_WAIT: begin
                if (cnt_reg == DELAY_CNT) begin
                    state_next  = RD_SEND;
                    beat_next   = '0;
                    c2_oe_next  = 1'b1;
                    d2_oe_next  = 1'b1;
                    d2_out_next = merged_beat[0];
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RD_SEND: begin
                if (beat_reg == LAST_BEAT) begin
                    state_next = IDLE;
                end else begin
                    beat_next   = beat_inc;
                    c2_oe_next  = 1'b1;
                    d2_oe_next  = 1'b1;
                    d2_out_next = merged_beat[beat_inc];
                end
            end
            WR_RECV: begin
                // C2 is deliberately not decoded while beats are arriving
                cap_en   = 1'b1;
                cnt_next = cnt_reg + 1'b1;
                if (beat_reg == LAST_BEAT) begin
                    state_next = WR_WAIT;
                end else begin
                    beat_next = beat_inc;
                end
            end
            WR_WAIT: begin
                if (cnt_reg == DELAY_CNT) begin
                    commit_en  = 1'b1;
                    c2_oe_next = 1'b1;
                    state_next = WR_ACK;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            WR_ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            beat_reg   <= '0;
            addr_reg   <= '0;
            c2_oe_reg  <= 1'b0;
            d2_oe_reg  <= 1'b0;
            d2_out_reg <= '0;
            dirty_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            beat_reg   <= beat_next;
            addr_reg   <= addr_next;
            c2_oe_reg  <= c2_oe_next;
            d2_oe_reg  <= d2_oe_next;
            d2_out_reg <= d2_out_next;
            if (commit_en) begin
                dirty_reg[addr_reg] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cap_en) begin
            wr_line_reg[DATA2_BUS_SIZE*cap_beat +: DATA2_BUS_SIZE] <= D2;
        end
    end

    // The line is read continuously from the latched address; it is stable long
    // before the first response beat because of the response latency.
    always_ff @(posedge clk) begin
        if (commit_en && !reset) begin
            line_ram[addr_reg] <= wr_line_reg;
        end
        rd_line_reg   <= line_ram[addr_reg];
        dirty_hit_reg <= dirty_reg[addr_reg];
    end

    assign C2 = c2_oe_reg ? CMD_RESP   : {CTR2_BUS_SIZE{1'bz}};
    assign D2 = d2_oe_reg ? d2_out_reg : {DATA2_BUS_SIZE{1'bz}};

endmodule
